slt_seq_cmp: RTL and testbench
==============================

Name: slt_seq_cmp

Overview:
Parametrised multi-cycle set-less-than unit for the MIPS datapath. It generalises the single-cycle 32-bit SLT to any operand width and supports signed, unsigned and inverted (set-greater-or-equal) modes. The unit compares CHUNK bits per cycle from the MSB down and can stop at the first differing chunk. It uses a valid/ready handshake on both sides, so the execute stage can stall around it.

Parameters:
WIDTH, 32, operand and result width in bits.
CHUNK, 8, bits compared per cycle. WIDTH % CHUNK must be 0; otherwise elaboration fails. NCHUNK = WIDTH/CHUNK.
EARLY_EXIT, 1, 1 = finish at the first differing chunk; 0 = always take NCHUNK cycles (constant timing).

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
flush  in  1  synchronous abort of any in-flight operation.
in_valid  in  1  operands and mode are valid.
in_ready  out  1  unit can accept an operation.
data0  in  WIDTH  operand A (result is A<B).
data1  in  WIDTH  operand B.
mode  in  2  bit0: 1=signed, 0=unsigned; bit1: 1=invert result (A>=B).
out_valid  out  1  result is valid.
out_ready  in  1  consumer accepts the result.
out  out  WIDTH  result: out[0] = set bit; out[WIDTH-1:1] = 0.
lt, eq, gt  out  1 each  A<B, A==B, A>B under the selected signedness. They are not affected by mode[1].

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - out=0, lt=eq=gt=0, out_valid=0, in_ready=0 while reset is held.
  - in_ready=1 from the first clock edge after reset is released.
- FSM has three states: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready at an edge: register A, B and mode, set chunk index k=0 (MSB chunk), go to CMP.
  - Signed handling: the MSB of both registered operands is XORed with mode[0] at capture. Every chunk comparison is then unsigned.
- CMP:
  - in_ready=0, out_valid=0.
  - Each cycle compares chunk k, i.e. bits [WIDTH-1-k*CHUNK -: CHUNK].
  - Chunks differ and EARLY_EXIT=1: latch lt/gt from this chunk, go to DONE.
  - Chunks differ and EARLY_EXIT=0: record the decision only if none is recorded yet, then continue.
  - k = NCHUNK-1 and no decision recorded: eq=1.
  - k = NCHUNK-1: go to DONE with the recorded flags.
  - Otherwise k increments by 1.
- DONE:
  - out_valid=1 and out[0] = lt XOR mode[1]. out and the flags are held stable.
  - On out_valid & out_ready: go to IDLE.
  - in_ready returns to 1 in the cycle after the result is consumed. There is no same-cycle back-to-back accept.
- Latency, counted from the accept edge to out_valid rising:
  - k+1 cycles, where k is the index of the first differing chunk.
  - NCHUNK cycles when the operands are equal or when EARLY_EXIT=0.
  - Minimum 1, maximum NCHUNK.
- flush=1 at an edge in any state:
  - Go to IDLE; out_valid deasserts.
  - Flags and out are cleared to 0.
  - Any result not yet consumed is discarded.
  - flush takes priority over accept and over the DONE handshake.
- in_valid while in_ready=0 is ignored. Inputs are sampled only at the accept edge, so operand changes during CMP or DONE have no effect.
- Exactly one of lt/eq/gt is 1 whenever out_valid=1.
- Reset asserted mid-operation: immediate return to the reset values. No result is produced for the aborted operation.

Test Plan:
1. WIDTH=32, CHUNK=8, EARLY_EXIT=1. A=0xFFFFFFFF, B=0x00000001, mode=01 (signed) -> out=0x00000001, lt=1. out_valid rises 1 cycle after accept.
2. Same operands, mode=00 (unsigned) -> out=0, gt=1, latency 1. Same operands, mode=10 (unsigned, inverted) -> out=1.
3. A=B=0x12345678, mode=01 -> eq=1, out=0, latency 4. Same operands, mode=11 -> out=1, eq=1.
4. A=0x00000100, B=0x00000101, unsigned -> decided at chunk 3, latency 4, lt=1. Rerun test 1 with EARLY_EXIT=0 -> latency 4, lt=1 (MSB-chunk decision retained).
5. Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid=1, out and flags stable, in_ready=0. Raise out_ready -> in_ready=1 the following cycle. A second op presented meanwhile is accepted only then.
6. Interruptions:
   - flush during CMP (WIDTH=32, equal operands, cycle 2) -> IDLE next edge, no out_valid pulse.
   - Assert reset asynchronously in DONE -> out_valid and out drop to 0 before the next clock edge.
   - Release reset -> in_ready=1 after the first edge.

Source files
------------

// File: rtl/slt_seq_cmp.sv
// Multi-cycle set-less-than unit: compares CHUNK bits per cycle from the MSB down,
// with signed/unsigned and inverted (greater-or-equal) modes.
module slt_seq_cmp #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0]    K_LAST   = KW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("slt_seq_cmp: WIDTH must be a multiple of CHUNK");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is registered, so it rises in the cycle after the unit returns to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic             inv_q, inv_d;
  logic             rlt_q, rlt_d, rgt_q, rgt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic [CHUNK-1:0] a_top, b_top;
  logic             c_lt, c_gt, new_lt, new_gt, finish;

  // Operands shift left each CMP cycle so the chunk under test is always the top one.
  assign a_top = a_q[WIDTH-1 -: CHUNK];
  assign b_top = b_q[WIDTH-1 -: CHUNK];
  assign c_lt  = (a_top < b_top);
  assign c_gt  = (a_top > b_top);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    inv_d       = inv_q;
    rlt_d       = rlt_q;
    rgt_d       = rgt_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    new_lt      = rlt_q;
    new_gt      = rgt_q;
    finish      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = data0 ^ (mode[0] ? MSB_MASK : '0);
          b_d     = data1 ^ (mode[0] ? MSB_MASK : '0);
          inv_d   = mode[1];
          k_d     = '0;
          rlt_d   = 1'b0;
          rgt_d   = 1'b0;
          out_d   = '0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        a_d = a_q << CHUNK;
        b_d = b_q << CHUNK;
        // Only the most significant differing chunk decides the result.
        if ((c_lt || c_gt) && !(rlt_q || rgt_q)) begin
          new_lt = c_lt;
          new_gt = c_gt;
        end
        finish = ((EARLY_EXIT != 0) && (c_lt || c_gt)) || (k_q == K_LAST);
        if (finish) begin
          lt_d        = new_lt;
          gt_d        = new_gt;
          eq_d        = !(new_lt || new_gt);
          out_d       = {{(WIDTH-1){1'b0}}, new_lt ^ inv_q};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          rlt_d = new_lt;
          rgt_d = new_gt;
          k_d   = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_d       = '0;
      lt_d        = 1'b0;
      eq_d        = 1'b0;
      gt_d        = 1'b0;
    end

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      inv_q       <= 1'b0;
      rlt_q       <= 1'b0;
      rgt_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      inv_q       <= inv_d;
      rlt_q       <= rlt_d;
      rgt_q       <= rgt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_slt_seq_cmp.sv
// Directed bench for slt_seq_cmp: an early-exit instance (u_dut0) and a
// constant-timing instance (u_dut1) sharing operands, mode, flush and reset.
module tb_slt_seq_cmp;

  localparam logic [2:0] F_LT   = 3'b100;
  localparam logic [2:0] F_EQ   = 3'b010;
  localparam logic [2:0] F_GT   = 3'b001;
  localparam logic [2:0] F_NONE = 3'b000;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] data0, data1;
  logic [1:0]  mode;

  logic        v0, ordy0, in_ready0, out_valid0, lt0, eq0, gt0;
  logic [31:0] out0;
  logic [1:0]  st0;
  logic        v1, ordy1, in_ready1, out_valid1, lt1, eq1, gt1;
  logic [31:0] out1;
  logic [1:0]  st1;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int pulses;

  always #5 clk = ~clk;

  slt_seq_cmp #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v0), .in_ready(in_ready0),
    .data0(data0), .data1(data1), .mode(mode),
    .out_valid(out_valid0), .out_ready(ordy0), .out(out0),
    .lt(lt0), .eq(eq0), .gt(gt0), .dbg_state(st0)
  );

  slt_seq_cmp #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v1), .in_ready(in_ready1),
    .data0(data0), .data1(data1), .mode(mode),
    .out_valid(out_valid1), .out_ready(ordy1), .out(out1),
    .lt(lt1), .eq(eq1), .gt(gt1), .dbg_state(st1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? in_ready1 : in_ready0;
  endfunction

  function automatic logic ov(input bit sel);
    return sel ? out_valid1 : out_valid0;
  endfunction

  function automatic logic [31:0] res(input bit sel);
    return sel ? out1 : out0;
  endfunction

  function automatic logic [2:0] flags(input bit sel);
    return sel ? {lt1, eq1, gt1} : {lt0, eq0, gt0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the accept edge, with in_valid dropped.
  task automatic start_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] m);
    data0 = a;
    data1 = b;
    mode  = m;
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    for (int i = 0; i < 20 && !rdy(sel); i++) tick();
    tick();
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic wait_out(input bit sel, output int l);
    l = 0;
    do begin
      tick();
      l++;
    end while (!ov(sel) && l < 20);
  endtask

  task automatic consume(input bit sel);
    if (sel) ordy1 = 1'b1; else ordy0 = 1'b1;
    tick();
    ordy0 = 1'b0;
    ordy1 = 1'b0;
  endtask

  task automatic do_op(input bit sel, input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] m,
                       input logic [31:0] exp_out, input logic [2:0] exp_flags,
                       input int exp_lat);
    int l;
    start_op(sel, a, b, m);
    wait_out(sel, l);
    check({tag, "_lat"}, l, exp_lat);
    check({tag, "_out"}, res(sel), exp_out);
    check({tag, "_flags"}, {29'd0, flags(sel)}, {29'd0, exp_flags});
    consume(sel);
    check({tag, "_valid_drop"}, {31'd0, ov(sel)}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, rdy(sel)}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    data0 = '0;
    data1 = '0;
    mode  = '0;
    v0 = 1'b0; ordy0 = 1'b0;
    v1 = 1'b0; ordy1 = 1'b0;

    repeat (2) tick();
    check("rst_in_ready", {31'd0, in_ready0}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check("rst_out", out0, 32'd0);
    check("rst_flags", {29'd0, lt0, eq0, gt0}, 32'd0);
    reset = 1'b1;
    check("rel_ready_pre_edge", {31'd0, in_ready0}, 32'd0);
    tick();
    check("rel_ready_post_edge", {31'd0, in_ready0}, 32'd1);

    // Early exit, signed / unsigned / inverted
    do_op(0, "t1_signed",   32'hFFFF_FFFF, 32'h0000_0001, 2'b01, 32'd1, F_LT, 1);
    do_op(0, "t2_unsigned", 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'd0, F_GT, 1);
    do_op(0, "t2_inv",      32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 32'd1, F_GT, 1);
    do_op(0, "t3_eq",       32'h1234_5678, 32'h1234_5678, 2'b01, 32'd0, F_EQ, 4);
    do_op(0, "t3_eq_inv",   32'h1234_5678, 32'h1234_5678, 2'b11, 32'd1, F_EQ, 4);
    do_op(0, "t4_chunk3",   32'h0000_0100, 32'h0000_0101, 2'b00, 32'd1, F_LT, 4);
    do_op(0, "s_minmax",    32'h8000_0000, 32'h7FFF_FFFF, 2'b01, 32'd1, F_LT, 1);
    do_op(0, "u_minmax",    32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 32'd0, F_GT, 1);
    do_op(0, "s_neg_low",   32'hFFFF_FF00, 32'hFFFF_FF80, 2'b01, 32'd1, F_LT, 4);
    do_op(0, "chunk1",      32'h00AB_0000, 32'h00AA_FFFF, 2'b00, 32'd0, F_GT, 2);

    // Constant timing: decision from the MSB chunk is kept
    do_op(1, "t4_const",    32'hFFFF_FFFF, 32'h0000_0001, 2'b01, 32'd1, F_LT, 4);
    do_op(1, "const_keep",  32'h0100_0002, 32'h0200_0001, 2'b00, 32'd1, F_LT, 4);
    do_op(1, "const_eq",    32'hCAFE_F00D, 32'hCAFE_F00D, 2'b10, 32'd1, F_EQ, 4);

    // Backpressure with a second op waiting
    start_op(0, 32'd5, 32'd3, 2'b00);
    wait_out(0, lat);
    check("t5_lat", lat, 4);
    data0 = 32'd1;
    data1 = 32'd2;
    mode  = 2'b00;
    v0    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_valid", {31'd0, out_valid0}, 32'd1);
      check("t5_hold_out", out0, 32'd0);
      check("t5_hold_flags", {29'd0, lt0, eq0, gt0}, {29'd0, F_GT});
      check("t5_hold_ready", {31'd0, in_ready0}, 32'd0);
    end
    ordy0 = 1'b1;
    tick();
    ordy0 = 1'b0;
    check("t5_consumed_valid", {31'd0, out_valid0}, 32'd0);
    check("t5_consumed_ready", {31'd0, in_ready0}, 32'd1);
    check("t5_not_yet_accepted", {30'd0, st0}, 32'd0);
    tick();
    v0 = 1'b0;
    check("t5_accepted", {30'd0, st0}, 32'd1);
    check("t5_busy_ready", {31'd0, in_ready0}, 32'd0);
    data0 = 32'hFFFF_FFFF;
    wait_out(0, lat);
    check("t5b_lat", lat, 4);
    check("t5b_out", out0, 32'd1);
    check("t5b_flags", {29'd0, lt0, eq0, gt0}, {29'd0, F_LT});
    consume(0);

    // Flush during CMP
    start_op(0, 32'h1234_5678, 32'h1234_5678, 2'b01);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_state", {30'd0, st0}, 32'd0);
    check("t6_flush_valid", {31'd0, out_valid0}, 32'd0);
    check("t6_flush_ready", {31'd0, in_ready0}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid0) pulses++;
    end
    check("t6_no_pulse", pulses, 0);
    do_op(0, "t6_after_flush", 32'h0000_0002, 32'h0000_0001, 2'b00, 32'd0, F_GT, 4);

    // Flush in DONE discards the result
    start_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b01);
    wait_out(0, lat);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_done_valid", {31'd0, out_valid0}, 32'd0);
    check("t6_flush_done_out", out0, 32'd0);
    check("t6_flush_done_flags", {29'd0, lt0, eq0, gt0}, {29'd0, F_NONE});

    // Asynchronous reset in DONE
    tick();
    start_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b01);
    wait_out(0, lat);
    check("t6r_pre_valid", {31'd0, out_valid0}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6r_async_valid", {31'd0, out_valid0}, 32'd0);
    check("t6r_async_out", out0, 32'd0);
    check("t6r_async_flags", {29'd0, lt0, eq0, gt0}, 32'd0);
    check("t6r_async_ready", {31'd0, in_ready0}, 32'd0);
    check("t6r_async_state", {30'd0, st0}, 32'd0);
    tick();
    check("t6r_held_ready", {31'd0, in_ready0}, 32'd0);
    reset = 1'b1;
    check("t6r_rel_pre_edge", {31'd0, in_ready0}, 32'd0);
    tick();
    check("t6r_rel_post_edge", {31'd0, in_ready0}, 32'd1);
    check("t6r_rel_valid", {31'd0, out_valid0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
